// File: rtl/keccak_msg_sched_if.sv
// Requester-side and core-side signals of the keccak message scheduler.
// slave is the scheduler's view; master is the environment's view.
interface keccak_msg_sched_if #(
  parameter int unsigned N_REQ = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_last;
  logic [2*N_REQ-1:0]  req_bytes;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    dig_valid;
  logic [N_REQ-1:0]    dig_ack;
  logic [511:0]        dig_out;
  logic [N_REQ-1:0]    grant;
  logic                busy;
  logic                core_reset;
  logic [31:0]         core_in;
  logic                core_in_ready;
  logic                core_is_last;
  logic [1:0]          core_byte_num;
  logic                core_buffer_full;
  logic [511:0]        core_out;
  logic                core_out_ready;

  modport slave (
    input  req_valid, req_data, req_last, req_bytes, dig_ack,
    input  core_buffer_full, core_out, core_out_ready,
    output req_ready, dig_valid, dig_out, grant, busy,
    output core_reset, core_in, core_in_ready, core_is_last, core_byte_num
  );

  modport master (
    output req_valid, req_data, req_last, req_bytes, dig_ack,
    output core_buffer_full, core_out, core_out_ready,
    input  req_ready, dig_valid, dig_out, grant, busy,
    input  core_reset, core_in, core_in_ready, core_is_last, core_byte_num
  );
endinterface

// File: rtl/keccak_msg_sched.sv
// Round-robin scheduler sharing one keccak core among N_REQ message sources:
// resets the core per message, streams words, adds the trailing pad word, returns the digest.
module keccak_msg_sched #(
  parameter int unsigned N_REQ = 2
) (
  input logic               clk,
  input logic               reset,
  keccak_msg_sched_if.slave bus
);
  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {StIdle, StClr, StFeed, StPad, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    gidx_q, gidx_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] dig_valid_q, dig_valid_d;
  logic [511:0]     dig_out_q, dig_out_d;
  logic             busy_q, busy_d;
  logic             core_reset_q, core_reset_d;

  logic             pick_found;
  logic [GW-1:0]    pick_idx;
  int unsigned      cand;
  int unsigned      gsel;
  logic             acc;
  logic [1:0]       last_bytes;

  // Scan ptr+1, ptr+2, ... so the most recently served requester comes last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(ptr_q) + k) % N_REQ;
      if (!pick_found && bus.req_valid[GW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(cand);
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    gidx_d             = gidx_q;
    ptr_d              = ptr_q;
    grant_d            = grant_q;
    dig_out_d          = dig_out_q;
    gsel               = 32'(gidx_q);
    acc                = 1'b0;
    last_bytes         = bus.req_bytes[2*gsel +: 2];
    bus.req_ready      = '0;
    bus.core_in        = '0;
    bus.core_in_ready  = 1'b0;
    bus.core_is_last   = 1'b0;
    bus.core_byte_num  = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          gidx_d           = pick_idx;
          grant_d          = '0;
          grant_d[pick_idx] = 1'b1;
          state_d          = StClr;
        end
      end
      StClr: state_d = StFeed;
      StFeed: begin
        acc                   = bus.req_valid[gidx_q] & ~bus.core_buffer_full;
        bus.req_ready[gidx_q] = acc;
        bus.core_in_ready     = acc;
        bus.core_in           = bus.req_data[32*gsel +: 32];
        // A full final word goes out as non-last; the empty pad word closes it.
        bus.core_is_last      = bus.req_last[gidx_q] & (last_bytes != 2'd0);
        bus.core_byte_num     = bus.core_is_last ? last_bytes : 2'd0;
        if (acc && bus.req_last[gidx_q]) begin
          state_d = (last_bytes != 2'd0) ? StWait : StPad;
        end
      end
      StPad: begin
        bus.core_is_last  = 1'b1;
        bus.core_in_ready = ~bus.core_buffer_full;
        if (!bus.core_buffer_full) state_d = StWait;
      end
      StWait: begin
        if (bus.core_out_ready) begin
          dig_out_d = bus.core_out;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (bus.dig_ack[gidx_q]) begin
          grant_d = '0;
          ptr_d   = gidx_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d       = (state_d != StIdle);
    core_reset_d = (state_d == StClr);
    dig_valid_d  = (state_d == StDone) ? grant_d : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      gidx_q       <= '0;
      ptr_q        <= GW'(N_REQ - 1);
      grant_q      <= '0;
      dig_valid_q  <= '0;
      dig_out_q    <= '0;
      busy_q       <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      gidx_q       <= gidx_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      dig_valid_q  <= dig_valid_d;
      dig_out_q    <= dig_out_d;
      busy_q       <= busy_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.dig_valid  = dig_valid_q;
  assign bus.dig_out    = dig_out_q;
  assign bus.busy       = busy_q;
  assign bus.core_reset = core_reset_q;
endmodule

// File: tb/tb_keccak_msg_sched.sv
// Randomized bench for keccak_msg_sched: a stand-in core hashes the word stream it receives,
// and each digest is checked against the stream the message bytes should produce.
module tb_keccak_msg_sched;
  localparam int unsigned N_REQ = 2;

  typedef logic [34:0] ent_t;  // {is_last, byte_num, word}
  typedef ent_t ent_q_t[$];

  logic clk = 1'b0;
  logic reset;

  keccak_msg_sched_if #(.N_REQ(N_REQ)) bus ();

  keccak_msg_sched #(.N_REQ(N_REQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] msg_mem [N_REQ][64];
  int         msg_len [N_REQ];
  ent_t       core_q[$];
  int         grant_log[$];
  bit         force_full = 1'b0;
  bit         rand_full  = 1'b0;
  bit         gaps_on    = 1'b0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N_REQ-1:0] onehot(input int r);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  function automatic logic [511:0] toy_hash(input ent_q_t q);
    logic [511:0] h;
    h = {8{64'h6A09E667F3BCC908}};
    foreach (q[i]) begin
      h = {h[472:0], h[511:473]} ^ {477'd0, q[i]};
      h[63:0] = h[63:0] + {29'd0, q[i]} * 64'h9E3779B97F4A7C15;
    end
    return h;
  endfunction

  function automatic logic [31:0] pack_word(input int r, input int w);
    logic [31:0] d;
    d = '0;
    for (int b = 0; b < 4; b++)
      if (4*w + b < msg_len[r]) d[31-8*b -: 8] = msg_mem[r][4*w+b];
    return d;
  endfunction

  // Expected core stream: words in order, last word flagged with its byte count,
  // or an extra empty last word when the message fills its final word.
  function automatic ent_q_t exp_stream(input int r);
    ent_q_t q;
    int     nw, lb;
    nw = (msg_len[r] + 3) / 4;
    lb = msg_len[r] % 4;
    for (int w = 0; w < nw; w++) begin
      if (w < nw - 1) q.push_back({3'b000, pack_word(r, w)});
      else if (lb != 0) q.push_back({1'b1, 2'(lb), pack_word(r, w)});
      else begin
        q.push_back({3'b000, pack_word(r, w)});
        q.push_back({3'b100, 32'h0});
      end
    end
    return q;
  endfunction

  task automatic load_str(input int r, input string s);
    msg_len[r] = s.len();
    for (int i = 0; i < s.len(); i++) msg_mem[r][i] = s[i];
  endtask

  task automatic load_rand(input int r, input int len);
    msg_len[r] = len;
    for (int i = 0; i < len; i++) msg_mem[r][i] = 8'($urandom);
  endtask

  // Stand-in core plus per-cycle owner checks, sampled 1 time unit before posedge.
  initial begin
    int               lat_cnt;
    logic [N_REQ-1:0] prev_grant;
    lat_cnt              = 0;
    prev_grant           = '0;
    bus.core_out         = '0;
    bus.core_out_ready   = 1'b0;
    bus.core_buffer_full = 1'b0;
    forever begin
      @(negedge clk);
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          bus.core_out       = toy_hash(core_q);
          bus.core_out_ready = 1'b1;
        end
      end
      bus.core_buffer_full = force_full | (rand_full && $urandom_range(0, 3) == 0);
      #4;
      if (bus.core_reset) begin
        core_q.delete();
        bus.core_out_ready = 1'b0;
        lat_cnt            = 0;
      end else if (bus.core_in_ready) begin
        core_q.push_back({bus.core_is_last, bus.core_byte_num, bus.core_in});
        if (bus.core_is_last) lat_cnt = $urandom_range(1, 6);
      end
      if (bus.core_buffer_full) begin
        check_eq("full_in_ready", bus.core_in_ready, 0);
        check_eq("full_req_ready", bus.req_ready, 0);
      end
      check_eq("ready_owner", bus.req_ready & ~bus.grant, 0);
      check_eq("dig_valid_owner", bus.dig_valid & ~bus.grant, 0);
      if (bus.grant != prev_grant && bus.grant != '0)
        for (int i = 0; i < N_REQ; i++) if (bus.grant[i]) grant_log.push_back(i);
      prev_grant = bus.grant;
    end
  end

  task automatic send_msg(input int r, input int rst_at, output bit ok);
    int nw, lb, budget;
    nw = (msg_len[r] + 3) / 4;
    lb = msg_len[r] % 4;
    ok = 1'b1;
    for (int w = 0; w < nw; w++) begin
      @(negedge clk);
      if (w == rst_at) begin
        reset = 1'b1;
        #1;
        check_eq("abort_grant", bus.grant, 0);
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_core_reset", bus.core_reset, 1);
        bus.req_valid[r] = 1'b0;
        bus.req_last[r]  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ok    = 1'b0;
        return;
      end
      while (gaps_on && $urandom_range(0, 3) == 0) begin
        bus.req_valid[r] = 1'b0;
        @(negedge clk);
      end
      bus.req_valid[r]          = 1'b1;
      bus.req_data[32*r +: 32]  = pack_word(r, w);
      bus.req_last[r]           = (w == nw - 1);
      bus.req_bytes[2*r +: 2]   = (w == nw - 1) ? 2'(lb) : 2'd0;
      budget = 0;
      #4;
      while (!bus.req_ready[r]) begin
        budget++;
        if (budget > 3000) begin
          check_eq("accept_timeout", 0, 1);
          bus.req_valid[r] = 1'b0;
          ok = 1'b0;
          return;
        end
        @(negedge clk);
        #4;
      end
    end
    @(negedge clk);
    bus.req_valid[r] = 1'b0;
    bus.req_last[r]  = 1'b0;
  endtask

  task automatic recv_dig(input int r, input int hold, input logic [511:0] eh, input int nexp);
    int           budget, o;
    logic [511:0] snap;
    o      = (r + 1) % N_REQ;
    budget = 0;
    forever begin
      @(negedge clk);
      #4;
      if (bus.dig_valid[r]) break;
      budget++;
      if (budget > 3000) begin
        check_eq("digest_timeout", 0, 1);
        return;
      end
    end
    check_eq("digest", bus.dig_out, eh);
    check_eq("stream_len", core_q.size(), nexp);
    check_eq("dig_valid_onehot", bus.dig_valid, onehot(r));
    check_eq("grant_onehot", bus.grant, onehot(r));
    snap = bus.dig_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (o != r) bus.dig_ack[o] = (hold >= 20 && i == 5);
      #4;
      check_eq("hold_dig_out", bus.dig_out, snap);
      check_eq("hold_grant", bus.grant, onehot(r));
      check_eq("hold_dig_valid", bus.dig_valid, onehot(r));
    end
    @(negedge clk);
    bus.dig_ack = '0;
    bus.dig_ack[r] = 1'b1;
    @(negedge clk);
    bus.dig_ack[r] = 1'b0;
  endtask

  task automatic run_req(input int r, input int hold, input int rst_at);
    ent_q_t       exp;
    logic [511:0] eh;
    bit           ok;
    exp = exp_stream(r);
    eh  = toy_hash(exp);
    send_msg(r, rst_at, ok);
    if (ok) recv_dig(r, hold, eh, exp.size());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.req_bytes = '0;
    bus.dig_ack   = '0;
    repeat (3) @(negedge clk);
    #4;
    check_eq("rst_grant", bus.grant, 0);
    check_eq("rst_dig_valid", bus.dig_valid, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_core_reset", bus.core_reset, 1);
    check_eq("rst_dig_out", bus.dig_out, 0);
    check_eq("rst_req_ready", bus.req_ready, 0);
    @(negedge clk);
    reset = 1'b0;

    load_str(0, "Hello, world!");
    run_req(0, 0, -1);
    check_eq("hello_words", core_q.size(), 4);
    check_eq("hello_last_flags", core_q[3][34:32], 3'b101);

    load_str(0, "The quick brown fox jumps over the lazy dog.");
    run_req(0, 1, -1);
    check_eq("fox_words", core_q.size(), 12);
    check_eq("fox_word10_flags", core_q[10][34:32], 3'b000);
    check_eq("fox_pad", core_q[11], {3'b100, 32'h0});

    do_reset();
    grant_log.delete();
    load_rand(0, 9);
    load_rand(1, 17);
    fork
      begin
        run_req(0, 0, -1);
        load_rand(0, 4);
        run_req(0, 0, -1);
      end
      run_req(1, 2, -1);
    join
    check_eq("rr_count", grant_log.size(), 3);
    check_eq("rr_first", grant_log[0], 0);
    check_eq("rr_second", grant_log[1], 1);
    check_eq("rr_third", grant_log[2], 0);

    load_rand(0, 30);
    fork
      run_req(0, 0, -1);
      begin
        cnt = 0;
        while (core_q.size() < 3 && cnt < 1000) begin
          @(negedge clk);
          cnt++;
        end
        force_full = 1'b1;
        repeat (5) @(negedge clk);
        force_full = 1'b0;
      end
    join

    load_rand(0, 21);
    load_rand(1, 12);
    fork
      run_req(0, 20, -1);
      begin
        repeat (3) @(negedge clk);
        run_req(1, 0, -1);
      end
    join

    load_rand(1, 19);
    run_req(1, 0, 2);
    run_req(1, 0, -1);

    gaps_on   = 1'b1;
    rand_full = 1'b1;
    fork
      begin
        repeat (6) begin
          load_rand(0, $urandom_range(1, 40));
          run_req(0, $urandom_range(0, 3), -1);
        end
      end
      begin
        repeat (6) begin
          load_rand(1, $urandom_range(1, 40));
          run_req(1, $urandom_range(0, 3), -1);
        end
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
